// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU command issuer.
package alu_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_INSTR_W = 16;

  // Instruction bits that choose which ALU output lane is returned
  localparam int unsigned LANE_HI = 13;
  localparam int unsigned LANE_LO = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Host command/response channels plus the ALU drive/observe bus.
interface alu_cmd_issuer_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [INSTR_W-1:0] cmd_instr;
  logic [DATA_W-1:0]  cmd_data0;
  logic [DATA_W-1:0]  cmd_data1;

  logic [INSTR_W-1:0] alu_instruction;
  logic [DATA_W-1:0]  alu_data0;
  logic [DATA_W-1:0]  alu_data1;
  logic [DATA_W-1:0]  alu_out0;
  logic [DATA_W-1:0]  alu_out1;
  logic [DATA_W-1:0]  alu_out2;
  logic [DATA_W-1:0]  alu_out3;
  logic               alu_overflow;
  logic               alu_zero;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_result;
  logic               rsp_overflow;
  logic               rsp_zero;

  modport master (
    input  cmd_valid, cmd_instr, cmd_data0, cmd_data1,
    input  alu_out0, alu_out1, alu_out2, alu_out3, alu_overflow, alu_zero,
    input  rsp_ready,
    output cmd_ready, alu_instruction, alu_data0, alu_data1,
    output rsp_valid, rsp_result, rsp_overflow, rsp_zero
  );

  modport slave (
    output cmd_valid, cmd_instr, cmd_data0, cmd_data1,
    output alu_out0, alu_out1, alu_out2, alu_out3, alu_overflow, alu_zero,
    output rsp_ready,
    input  cmd_ready, alu_instruction, alu_data0, alu_data1,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and full/empty flags.
module cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers host commands, drives them one at a time into the ALU and
// returns the selected result lane and flags on a response channel.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_issuer_if.master  bus
);
  localparam int unsigned CMD_W = INSTR_W + 2 * DATA_W;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               pop_c;
  logic               capture_c;
  logic               push_c;
  logic               full;
  logic               empty;
  logic [CMD_W-1:0]   head;
  logic [DATA_W-1:0]  lane_c;

  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  data0_q;
  logic [DATA_W-1:0]  data1_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_result_q;
  logic               rsp_overflow_q;
  logic               rsp_zero_q;

  assign push_c        = bus.cmd_valid & ~full;
  assign bus.cmd_ready = ~full;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata ({bus.cmd_instr, bus.cmd_data0, bus.cmd_data1}),
    .pop   (pop_c),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop_c      = 1'b0;
    capture_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop_c      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = CNT_W'(ALU_LAT - 1);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          capture_c  = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Only the lane-select field of the instruction is interpreted here
  always_comb begin
    case (instr_q[LANE_HI:LANE_LO])
      2'd0:    lane_c = bus.alu_out0;
      2'd1:    lane_c = bus.alu_out1;
      2'd2:    lane_c = bus.alu_out2;
      default: lane_c = bus.alu_out3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q        <= '0;
      data0_q        <= '0;
      data1_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
    end else begin
      if (pop_c) {instr_q, data0_q, data1_q} <= head;
      if (capture_c) begin
        rsp_valid_q    <= 1'b1;
        rsp_result_q   <= lane_c;
        rsp_overflow_q <= bus.alu_overflow;
        rsp_zero_q     <= bus.alu_zero;
      end else if (state == ST_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_instruction = instr_q;
  assign bus.alu_data0       = data0_q;
  assign bus.alu_data1       = data1_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_result      = rsp_result_q;
  assign bus.rsp_overflow    = rsp_overflow_q;
  assign bus.rsp_zero        = rsp_zero_q;

endmodule
